psk_framer: RTL and testbench

// - Upstream stage of the BPSK/QPSK modulator. Takes a payload byte stream (AXIS) and emits one

---
 rtl/psk_pkg.sv | 33 +++
 rtl/psk_framer_crc8_byte.sv | 21 ++
 rtl/psk_framer.sv | 180 ++++++++++++++++++
 tb/tb_psk_framer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psk_pkg.sv
// Shared constants, FSM encoding and symbol helpers for the PSK framer.
// PSK_FRAMER_CRC_EN adds the CRC state and polynomial.
package psk_pkg;

  localparam logic [15:0] BARKER13 = 16'h1F35;
`ifdef PSK_FRAMER_CRC_EN
  localparam logic [7:0]  CRC8_POLY = 8'h07;
`endif

  localparam int unsigned SYM_CNT_W = 4;
  localparam int unsigned PRE_IDX_W = 4;
  localparam logic [SYM_CNT_W-1:0] QPSK_SYMS = SYM_CNT_W'(4);
  localparam logic [SYM_CNT_W-1:0] BPSK_SYMS = SYM_CNT_W'(8);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_PAY  = 2'd2
`ifdef PSK_FRAMER_CRC_EN
    , ST_CRC = 2'd3
`endif
  } state_t;

  // Leading symbol of a byte: QPSK pair in [1:0], BPSK bit in [1].
  function automatic logic [7:0] sym_of(input logic [7:0] b, input logic qpsk);
    return qpsk ? {6'b0, b[7:6]} : {6'b0, b[7], 1'b0};
  endfunction

  function automatic logic [7:0] shift_of(input logic [7:0] b, input logic qpsk);
    return qpsk ? {b[5:0], 2'b00} : {b[6:0], 1'b0};
  endfunction

endpackage

// File: rtl/psk_framer_crc8_byte.sv
// Combinational CRC-8 (x^8+x^2+x+1) advanced by one byte, MSB first.
// Only present when PSK_FRAMER_CRC_EN is defined.
`ifdef PSK_FRAMER_CRC_EN
module crc8_byte
  import psk_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (crc_out[7] ^ data[i]) crc_out = {crc_out[6:0], 1'b0} ^ CRC8_POLY;
      else                      crc_out = {crc_out[6:0], 1'b0};
    end
  end

endmodule
`endif

// File: rtl/psk_framer.sv
// Byte-stream to BPSK/QPSK symbol framer: Barker preamble, then payload symbols.
// Define PSK_FRAMER_CRC_EN to append a CRC-8 byte after the payload.
module psk_framer
  import psk_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 13,
  parameter logic [15:0] PREAMBLE     = BARKER13
) (
  input  logic       clk_16M384,
  input  logic       rst_16M384,
  input  logic [7:0] in_tdata,
  input  logic       in_tvalid,
  output logic       in_tready,
  input  logic       in_tlast,
  input  logic       cfg_qpsk,
  output logic [7:0] out_tdata,
  output logic       out_tvalid,
  input  logic       out_tready,
  output logic       out_tlast,
  output logic       out_tuser,
  output logic       busy,
  output logic       underrun
);

  state_t                 state;
  logic                   qpsk;
  logic [PRE_IDX_W-1:0]   pre_idx;
  logic [7:0]             sreg;
  logic [SYM_CNT_W-1:0]   scnt;
  logic                   byte_last;
  logic                   out_eob;
  logic                   started;
  logic                   gap;

  logic                   fire;
  logic                   slot;
  logic                   accept;
  logic [SYM_CNT_W-1:0]   nsym;

  assign fire   = out_tvalid & out_tready;
  assign slot   = ~out_tvalid | out_tready;
  assign accept = in_tvalid & in_tready;
  assign nsym   = qpsk ? QPSK_SYMS : BPSK_SYMS;

`ifdef PSK_FRAMER_CRC_EN
  logic [7:0] crc;
  logic [7:0] crc_nxt;
  logic       tl_seen;

  crc8_byte u_crc (
    .crc_in  (crc),
    .data    (in_tdata),
    .crc_out (crc_nxt)
  );
`endif

  // out_eob marks the output symbol that empties the current byte; its handshake frees the buffer.
  always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
    if (rst_16M384) begin
      state      <= ST_IDLE;
      qpsk       <= 1'b0;
      pre_idx    <= '0;
      sreg       <= '0;
      scnt       <= '0;
      byte_last  <= 1'b0;
      out_eob    <= 1'b0;
      started    <= 1'b0;
      gap        <= 1'b0;
      in_tready  <= 1'b0;
      out_tdata  <= '0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      out_tuser  <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
`ifdef PSK_FRAMER_CRC_EN
      crc        <= '0;
      tl_seen    <= 1'b0;
`endif
    end else begin
      underrun <= 1'b0;
      if (fire) out_tvalid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (in_tvalid) begin
            state   <= ST_PRE;
            busy    <= 1'b1;
            qpsk    <= cfg_qpsk;
            pre_idx <= PRE_IDX_W'(PREAMBLE_LEN - 1);
            sreg    <= '0;
            scnt    <= '0;
            started <= 1'b0;
            gap     <= 1'b0;
`ifdef PSK_FRAMER_CRC_EN
            crc     <= '0;
            tl_seen <= 1'b0;
`endif
          end
        end

        ST_PRE: begin
          if (slot) begin
            out_tvalid <= 1'b1;
            out_tdata  <= {6'b0, PREAMBLE[pre_idx], 1'b0};
            out_tuser  <= 1'b1;
            out_tlast  <= 1'b0;
            out_eob    <= 1'b0;
            if (pre_idx == '0) begin
              state     <= ST_PAY;
              in_tready <= 1'b1;
            end else begin
              pre_idx <= pre_idx - PRE_IDX_W'(1);
            end
          end
        end

        // Payload and CRC share the shift-register datapath.
        default: begin
          if (accept) begin
            in_tready <= 1'b0;
            started   <= 1'b1;
            gap       <= 1'b0;
`ifdef PSK_FRAMER_CRC_EN
            crc       <= crc_nxt;
            tl_seen   <= in_tlast;
            byte_last <= 1'b0;
`else
            byte_last <= in_tlast;
`endif
            if (slot) begin
              out_tvalid <= 1'b1;
              out_tdata  <= sym_of(in_tdata, qpsk);
              out_tuser  <= ~qpsk;
              out_tlast  <= 1'b0;
              out_eob    <= 1'b0;
              sreg       <= shift_of(in_tdata, qpsk);
              scnt       <= nsym - SYM_CNT_W'(1);
            end else begin
              sreg <= in_tdata;
              scnt <= nsym;
            end
          end else if (in_tready) begin
            if (started && !gap) begin
              underrun <= 1'b1;
              gap      <= 1'b1;
            end
          end else if (slot && scnt != '0) begin
            out_tvalid <= 1'b1;
            out_tdata  <= sym_of(sreg, qpsk);
            out_tuser  <= ~qpsk;
            out_tlast  <= byte_last && (scnt == SYM_CNT_W'(1));
            out_eob    <= (scnt == SYM_CNT_W'(1));
            sreg       <= shift_of(sreg, qpsk);
            scnt       <= scnt - SYM_CNT_W'(1);
          end

          if (fire && out_eob) begin
            if (out_tlast) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
`ifdef PSK_FRAMER_CRC_EN
            else if (tl_seen) begin
              state     <= ST_CRC;
              sreg      <= crc;
              scnt      <= nsym;
              byte_last <= 1'b1;
            end
`endif
            else begin
              in_tready <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psk_framer.sv
// Self-checking bench for psk_framer: literal sequences, a vector table and random frames
// against a symbol-list reference model (CRC byte included when PSK_FRAMER_CRC_EN is defined).
`timescale 1ns/1ps
module tb_psk_framer;

  localparam int GAP_LEN = 40;

  typedef struct packed {
    logic [7:0] data;
    logic       user;
    logic       last;
  } sym_t;

  typedef struct {
    logic [7:0] b [4];
    int         nb;
    bit         q;
    bit         bp;
    int         gap_at;
    int         exp_nsym;
    int         exp_urun;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_tdata = '0;
  logic       in_tvalid = 1'b0;
  logic       in_tready;
  logic       in_tlast = 1'b0;
  logic       cfg_qpsk = 1'b0;
  logic [7:0] out_tdata;
  logic       out_tvalid;
  logic       out_tready = 1'b1;
  logic       out_tlast;
  logic       out_tuser;
  logic       busy;
  logic       underrun;

  int   checks = 0;
  int   errors = 0;
  sym_t cap[$];
  sym_t exp_q[$];
  bit   bp_mode = 1'b0;
  bit   last_seen = 1'b0;
  bit   cur_q = 1'b0;
  int   urun_cnt = 0;
  int   pay_done = 0;
  int   bytes_acc = 0;
  bit   prev_hold = 1'b0;
  sym_t prev_sym;

  psk_framer dut (
    .clk_16M384 (clk),
    .rst_16M384 (rst),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .in_tlast   (in_tlast),
    .cfg_qpsk   (cfg_qpsk),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tlast  (out_tlast),
    .out_tuser  (out_tuser),
    .busy       (busy),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Downstream ready: always 1, or a coin toss per cycle under backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_tready = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: capture handshaked symbols, check hold stability and the one-byte-buffer rule.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        sym_t s;
        s.data = out_tdata;
        s.user = out_tuser;
        s.last = out_tlast;
        if (prev_hold) check("hold_stable", 32'({out_tvalid, s}), 32'({1'b1, prev_sym}));
        if (in_tready) check("in_tready_empty", 32'(pay_done), 32'(bytes_acc * (cur_q ? 4 : 8)));
        if (in_tvalid && in_tready) bytes_acc++;
        if (underrun) urun_cnt++;
        if (out_tvalid && out_tready) begin
          if (cap.size() >= 13) pay_done++;
          cap.push_back(s);
          if (s.last) last_seen = 1'b1;
        end
        prev_hold = out_tvalid && !out_tready;
        prev_sym  = s;
      end
    end
  end

  // CRC as remainder of (message * x^8) divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_ref(input logic [7:0] b[$]);
    logic [8:0] r = '0;
    int nbits = b.size() * 8 + 8;
    for (int i = 0; i < nbits; i++) begin
      logic bitv;
      bitv = (i < b.size() * 8) ? b[i / 8][7 - (i % 8)] : 1'b0;
      r = {r[7:0], bitv};
      if (r[8]) r = r ^ 9'h107;
    end
    return r[7:0];
  endfunction

  task automatic build_model(input logic [7:0] b[$], input bit q);
    logic [15:0] pre = 16'h1F35;
    logic [7:0]  msg[$];
    sym_t        t;
    int          k, n;
    exp_q = {};
    for (int i = 0; i < 13; i++) begin
      t.data = {6'd0, pre[12 - i], 1'b0};
      t.user = 1'b1;
      t.last = 1'b0;
      exp_q.push_back(t);
    end
    msg = b;
`ifdef PSK_FRAMER_CRC_EN
    msg.push_back(crc_ref(b));
`endif
    k = q ? 2 : 1;
    n = 8 / k;
    for (int j = 0; j < msg.size(); j++) begin
      for (int s = 0; s < n; s++) begin
        int vb, v;
        vb = int'(msg[j]);
        v  = (vb >> (8 - k * (s + 1))) & ((1 << k) - 1);
        t.data = q ? 8'(v) : 8'(v * 2);
        t.user = !q;
        t.last = 1'b0;
        exp_q.push_back(t);
      end
    end
    t = exp_q[exp_q.size() - 1];
    t.last = 1'b1;
    exp_q[exp_q.size() - 1] = t;
  endtask

  task automatic clear_frame(input bit q);
    cap = {};
    last_seen = 1'b0;
    urun_cnt = 0;
    pay_done = 0;
    bytes_acc = 0;
    cur_q = q;
  endtask

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (in_tready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout actual=no_in_tready required=in_tready");
  endtask

  task automatic run_frame(input logic [7:0] b[$], input bit q, input bit bp, input int gap_at);
    bit ok;
    clear_frame(q);
    bp_mode = bp;
    @(posedge clk);
    #1;
    cfg_qpsk = q;
    for (int i = 0; i < b.size(); i++) begin
      if (i == gap_at) begin
        in_tvalid = 1'b0;
        repeat (GAP_LEN) @(posedge clk);
        #1;
        check("gap_tvalid", 32'(out_tvalid), 32'd0);
      end
      in_tvalid = 1'b1;
      in_tdata  = b[i];
      in_tlast  = (i == b.size() - 1);
      wait_accept(ok);
      if (!ok) begin
        in_tvalid = 1'b0;
        bp_mode = 1'b0;
        return;
      end
      cfg_qpsk = ~q;
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      @(posedge clk);
      if (last_seen) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL tlast_timeout actual=no_tlast required=tlast");
    end else begin
      check("busy_after_last", 32'(busy), 32'd0);
    end
    bp_mode = 1'b0;
  endtask

  task automatic compare_frame(input string nm, input logic [7:0] b[$], input bit q);
    int bad = -1;
    build_model(b, q);
    check({nm, "_nsym"}, 32'(cap.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
      if (bad < 0 && cap[i] !== exp_q[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s_stream symbol %0d actual=%h required=%h", nm, bad, cap[bad], exp_q[bad]);
    end
  endtask

  task automatic lit_check(input string nm, input int d[$], input int u[$], input int last_idx);
    int bad = -1;
    int li = -1;
    for (int i = 0; i < d.size(); i++)
      if (bad < 0 && (i >= cap.size() || cap[i].data !== 8'(d[i]) || cap[i].user !== 1'(u[i])))
        bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s_lit symbol %0d actual_ok=%0d required data=%0d user=%0d",
               nm, bad, (bad < cap.size()), d[bad], u[bad]);
    end
    for (int i = 0; i < cap.size(); i++) if (li < 0 && cap[i].last) li = i;
    check({nm, "_tlast_idx"}, 32'(li), 32'(last_idx));
    check({nm, "_len"}, 32'(cap.size()), 32'(last_idx + 1));
  endtask

  initial begin
    vec_t       vecs[6];
    logic [7:0] bq[$];
    int         d[$];
    int         u[$];
    int         crc_extra;
    bit         ok;

    vecs[0] = '{'{8'hB4, 8'h1E, 8'h00, 8'h00}, 2, 1'b1, 1'b0, -1, 21, 0};
    vecs[1] = '{'{8'hA5, 8'h00, 8'h00, 8'h00}, 1, 1'b0, 1'b0, -1, 21, 0};
    vecs[2] = '{'{8'hB4, 8'h1E, 8'h00, 8'h00}, 2, 1'b1, 1'b1, -1, 21, 0};
    vecs[3] = '{'{8'h3C, 8'hC3, 8'h5A, 8'h00}, 3, 1'b1, 1'b0,  1, 25, 1};
    vecs[4] = '{'{8'h00, 8'hFF, 8'h00, 8'h00}, 2, 1'b0, 1'b1, -1, 29, 0};
    vecs[5] = '{'{8'h81, 8'h7E, 8'h99, 8'h00}, 3, 1'b0, 1'b0,  2, 37, 1};

    #1;
    check("reset_outputs", 32'({in_tready, out_tdata, out_tvalid, out_tlast, out_tuser, busy, underrun}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // QPSK {B4, 1E}
    bq = {8'hB4, 8'h1E};
    run_frame(bq, 1'b1, 1'b0, -1);
    d = {2,2,2,2,2,0,0,2,2,0,2,0,2, 2,3,1,0,0,1,3,2};
    u = {1,1,1,1,1,1,1,1,1,1,1,1,1, 0,0,0,0,0,0,0,0};
`ifdef PSK_FRAMER_CRC_EN
    lit_check("qpsk_b4_1e", d, u, 24);
`else
    lit_check("qpsk_b4_1e", d, u, 20);
`endif

    // BPSK {A5}
    bq = {8'hA5};
    run_frame(bq, 1'b0, 1'b0, -1);
    d = {2,2,2,2,2,0,0,2,2,0,2,0,2, 2,0,2,0,0,2,0,2};
    u = {1,1,1,1,1,1,1,1,1,1,1,1,1, 1,1,1,1,1,1,1,1};
`ifdef PSK_FRAMER_CRC_EN
    lit_check("bpsk_a5", d, u, 28);
`else
    lit_check("bpsk_a5", d, u, 20);
`endif

`ifdef PSK_FRAMER_CRC_EN
    bq = {8'h01};
    run_frame(bq, 1'b1, 1'b0, -1);
    d = {2,2,2,2,2,0,0,2,2,0,2,0,2, 0,0,0,1, 0,0,1,3};
    u = {1,1,1,1,1,1,1,1,1,1,1,1,1, 0,0,0,0, 0,0,0,0};
    lit_check("crc_qpsk_01", d, u, 20);
`endif

    // Async reset during the 5th preamble symbol
    clear_frame(1'b1);
    @(posedge clk);
    #1;
    cfg_qpsk  = 1'b1;
    in_tvalid = 1'b1;
    in_tdata  = 8'h5A;
    in_tlast  = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      if (cap.size() >= 4) begin
        ok = 1'b1;
        break;
      end
    end
    #2;
    check("pre5_reached", 32'(ok), 32'd1);
    check("pre5_symbol", 32'({out_tvalid, out_tdata}), 32'({1'b1, 8'h02}));
    rst = 1'b1;
    #1;
    check("async_reset_outputs",
          32'({in_tready, out_tdata, out_tvalid, out_tlast, out_tuser, busy, underrun}), 32'd0);
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bq = {8'hB4, 8'h1E};
    run_frame(bq, 1'b1, 1'b0, -1);
    compare_frame("after_reset", bq, 1'b1);

    // Vector table
`ifdef PSK_FRAMER_CRC_EN
    crc_extra = 1;
`else
    crc_extra = 0;
`endif
    for (int v = 0; v < 6; v++) begin
      bq = {};
      for (int i = 0; i < vecs[v].nb; i++) bq.push_back(vecs[v].b[i]);
      run_frame(bq, vecs[v].q, vecs[v].bp, vecs[v].gap_at);
      compare_frame($sformatf("vec%0d", v), bq, vecs[v].q);
      check($sformatf("vec%0d_count", v), 32'(cap.size()),
            32'(vecs[v].exp_nsym + crc_extra * (vecs[v].q ? 4 : 8)));
      check($sformatf("vec%0d_underrun", v), 32'(urun_cnt), 32'(vecs[v].exp_urun));
    end

    // Random frames, random modulation and backpressure
    for (int r = 0; r < 8; r++) begin
      int nb;
      bit q;
      bit bp;
      nb = $urandom_range(1, 4);
      q  = ($urandom_range(0, 1) == 1);
      bp = ($urandom_range(0, 1) == 1);
      bq = {};
      for (int i = 0; i < nb; i++) bq.push_back(8'($urandom_range(0, 255)));
      run_frame(bq, q, bp, -1);
      compare_frame($sformatf("rand%0d", r), bq, q);
      check($sformatf("rand%0d_underrun", r), 32'(urun_cnt), 32'd0);
    end

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
